// File: rtl/apb_mac_pkg.sv
// Shared constants for the APB MAC array: register offsets, CTRL/STATUS bit
// positions and the per-channel sequencing states.
package apb_mac_pkg;

  localparam logic [3:0] OFF_OPERAND = 4'h0;
  localparam logic [3:0] OFF_CTRL    = 4'h4;
  localparam logic [3:0] OFF_RESULT  = 4'h8;
  localparam logic [3:0] OFF_STATUS  = 4'hC;

  localparam int CTRL_ACC_EN = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2
  } mac_state_e;

endpackage

// File: rtl/apb_mac_array_if.sv
// APB3 signal bundle between the peripheral bus master and the MAC array.
interface apb_mac_array_if;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/booth_r4_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per cycle, the first digit
// is folded into the start cycle so done pulses W/2 cycles after start.
module booth_r4_seq #(
  parameter int W = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  start,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] product,
  output logic                  done
);

  localparam int STEPS = W / 2;
  localparam int CW    = $clog2(STEPS + 1);

  logic signed [2*W-1:0] r_prod;
  logic signed [2*W-1:0] r_mcand;
  logic signed [W:0]     r_mplier;
  logic [CW-1:0]         r_cnt;
  logic                  r_run;
  logic                  r_done;

  logic [2:0]            w_trip;
  logic signed [2*W-1:0] w_mc;
  logic signed [2*W-1:0] w_base;
  logic signed [2*W-1:0] w_sum;

  // Wrap-around in 2W bits is harmless: the true product always fits in 2W.
  function automatic logic signed [2*W-1:0] booth_pp(input logic [2:0] t,
                                                     input logic signed [2*W-1:0] m);
    case (t)
      3'b001, 3'b010: booth_pp = m;
      3'b011:         booth_pp = m <<< 1;
      3'b100:         booth_pp = -(m <<< 1);
      3'b101, 3'b110: booth_pp = -m;
      default:        booth_pp = '0;
    endcase
  endfunction

  always_comb begin
    w_trip = start ? {b[1:0], 1'b0} : r_mplier[2:0];
    w_mc   = start ? (2*W)'(a) : r_mcand;
    w_base = start ? '0 : r_prod;
    w_sum  = w_base + booth_pp(w_trip, w_mc);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_prod   <= w_sum;
        r_mcand  <= w_mc <<< 2;
        r_mplier <= $signed({b, 1'b0}) >>> 2;
        r_cnt    <= CW'(STEPS - 1);
        r_run    <= 1'b1;
      end else if (r_run) begin
        r_prod   <= w_sum;
        r_mcand  <= r_mcand <<< 2;
        r_mplier <= r_mplier >>> 2;
        r_cnt    <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign product = r_prod;
  assign done    = r_done;

endmodule

// File: rtl/apb_mac_array.sv
// APB3 slave with NUM_CH independent signed MAC channels, each with its own
// Booth multiplier, accumulator, CTRL/STATUS registers and done interrupt.
module apb_mac_array
  import apb_mac_pkg::*;
#(
  parameter int          OPERAND_WIDTH = 8,
  parameter int          NUM_CH        = 2,
  parameter int          ACC_WIDTH     = 2 * OPERAND_WIDTH + 8,
  parameter logic [31:0] SLAVE_BASE    = 32'h0000_0000
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_mac_array_if.slave    apb,
  output logic [NUM_CH-1:0] MAC_DONE,
  output logic              IRQ
);

  localparam int W = OPERAND_WIDTH;

  logic [31:0]                w_off;
  logic [3:0]                 w_ch;
  logic [3:0]                 w_reg;
  logic                       w_valid;
  logic                       w_access;
  logic                       w_err;
  logic                       w_ok;
  logic                       w_sel_busy;
  logic [31:0]                w_sel_rd;
  logic [NUM_CH-1:0]          w_busy;
  logic [NUM_CH-1:0]          w_irq_vec;
  logic [NUM_CH-1:0][31:0]    w_rd_all;
  logic                       w_unused;

  assign w_off    = apb.PADDR - SLAVE_BASE;
  assign w_ch     = w_off[7:4];
  assign w_reg    = w_off[3:0];
  assign w_valid  = (w_off < 32'(NUM_CH * 16)) && (w_off[1:0] == 2'b00);
  assign w_access = apb.PSEL & apb.PENABLE;
  assign w_unused = ^apb.PWDATA;

  always_comb begin
    w_sel_busy = 1'b0;
    w_sel_rd   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == 4'(i)) begin
        w_sel_busy = w_busy[i];
        w_sel_rd   = w_rd_all[i];
      end
    end
    w_err = 1'b0;
    if (w_access) begin
      if (!w_valid) begin
        w_err = 1'b1;
      end else if (apb.PWRITE) begin
        case (w_reg)
          OFF_OPERAND: w_err = w_sel_busy;
          OFF_CTRL:    w_err = w_sel_busy & apb.PWDATA[CTRL_CLR];
          default:     w_err = 1'b1;
        endcase
      end
    end
  end

  // A rejected access never reaches a channel, so it cannot change state.
  assign w_ok        = w_access & w_valid & ~w_err;
  assign apb.PSLVERR = w_err;
  assign apb.PRDATA  = (w_ok && !apb.PWRITE) ? w_sel_rd : '0;
  assign apb.PREADY  = 1'b1;
  assign IRQ         = |w_irq_vec;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic                        w_sel;
    logic                        w_wr_op;
    logic                        w_wr_ctrl;
    logic                        w_rd_stat;
    logic                        w_bdone;
    logic                        w_ovf;
    logic signed [2*W-1:0]       w_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] w_next;
    logic [31:0]                 w_rdata;

    logic [W-1:0]                r_a;
    logic [W-1:0]                r_b;
    logic                        r_acc_en;
    logic                        r_irq_en;
    logic                        r_done;
    logic                        r_ovf;
    logic signed [ACC_WIDTH-1:0] r_acc;
    mac_state_e                  r_state;

    assign w_sel     = w_ok && (w_ch == 4'(g));
    assign w_wr_op   = w_sel & apb.PWRITE & (w_reg == OFF_OPERAND);
    assign w_wr_ctrl = w_sel & apb.PWRITE & (w_reg == OFF_CTRL);
    assign w_rd_stat = w_sel & ~apb.PWRITE & (w_reg == OFF_STATUS);

    booth_r4_seq #(.W(W)) u_booth (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .start   (w_wr_op),
      .a       (apb.PWDATA[2*W-1:W]),
      .b       (apb.PWDATA[W-1:0]),
      .product (w_prod),
      .done    (w_bdone)
    );

    assign w_prod_ext = ACC_WIDTH'(w_prod);
    assign w_sum      = r_acc + w_prod_ext;
    assign w_ovf      = r_acc_en && (r_acc[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1])
                        && (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
    assign w_next     = r_acc_en ? w_sum : w_prod_ext;

    // DONE/OVF sets are ordered after the STATUS-read clear so a set wins.
    always_ff @(posedge PCLK) begin
      if (PRESET) begin
        r_a      <= '0;
        r_b      <= '0;
        r_acc_en <= 1'b0;
        r_irq_en <= 1'b0;
        r_done   <= 1'b0;
        r_ovf    <= 1'b0;
        r_acc    <= '0;
        r_state  <= ST_IDLE;
      end else begin
        if (w_wr_op) begin
          r_a <= apb.PWDATA[2*W-1:W];
          r_b <= apb.PWDATA[W-1:0];
        end
        if (w_wr_ctrl) begin
          r_acc_en <= apb.PWDATA[CTRL_ACC_EN];
          r_irq_en <= apb.PWDATA[CTRL_IRQ_EN];
          if (apb.PWDATA[CTRL_CLR]) r_acc <= '0;
        end
        if (w_rd_stat) begin
          r_done <= 1'b0;
          r_ovf  <= 1'b0;
        end
        case (r_state)
          ST_IDLE: if (w_wr_op) r_state <= ST_MUL;
          ST_MUL:  if (w_bdone) r_state <= ST_ACC;
          ST_ACC: begin
            r_state <= ST_IDLE;
            r_acc   <= w_next;
            r_done  <= 1'b1;
            if (w_ovf) r_ovf <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end

    always_comb begin
      w_rdata = '0;
      case (w_reg)
        OFF_OPERAND: w_rdata = 32'({r_a, r_b});
        OFF_CTRL:    w_rdata = 32'({r_irq_en, 1'b0, r_acc_en});
        OFF_RESULT:  w_rdata = 32'(r_acc);
        OFF_STATUS:  w_rdata = 32'({r_ovf, r_done, (r_state != ST_IDLE)});
        default:     w_rdata = '0;
      endcase
    end

    assign w_busy[g]    = (r_state != ST_IDLE);
    assign w_rd_all[g]  = w_rdata;
    assign w_irq_vec[g] = r_done & r_irq_en;
    assign MAC_DONE[g]  = r_done;
  end

endmodule

// File: tb/tb_apb_mac_array.sv
// Directed self-checking bench for apb_mac_array (W=8, two channels, 16-bit
// accumulator so the overflow scenario is reachable with two products).
module tb_apb_mac_array;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic       clk;
  logic       rst;
  logic [1:0] mac_done;
  logic       irq;
  int         checks;
  int         errors;

  apb_mac_array_if apb_if ();

  apb_mac_array #(
    .OPERAND_WIDTH (8),
    .NUM_CH        (2),
    .ACC_WIDTH     (16),
    .SLAVE_BASE    (BASE)
  ) dut (
    .PCLK     (clk),
    .PRESET   (rst),
    .apb      (apb_if),
    .MAC_DONE (mac_done),
    .IRQ      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ra(input int ch, input int off);
    return BASE + 32'(ch * 16 + off);
  endfunction

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
    @(negedge clk);
    apb_if.PADDR = addr; apb_if.PWDATA = data; apb_if.PWRITE = 1'b1;
    apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0;
    @(negedge clk);
    apb_if.PENABLE = 1'b1;
    #1 err = apb_if.PSLVERR;
    @(posedge clk);
    #1 apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
    @(negedge clk);
    apb_if.PADDR = addr; apb_if.PWRITE = 1'b0;
    apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0;
    @(negedge clk);
    apb_if.PENABLE = 1'b1;
    #1 begin data = apb_if.PRDATA; err = apb_if.PSLVERR; end
    @(posedge clk);
    #1 apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0;
  endtask

  // Cycles until all bits of mask are set in MAC_DONE, or -1 after 30 cycles.
  task automatic wait_done(input logic [1:0] mask, output int cyc);
    cyc = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if ((mac_done & mask) == mask) begin cyc = k; break; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mac_done !== 2'b00) begin errors++; $display("FAIL reset_mac_done got %b exp 00", mac_done); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    checks++; if (apb_if.PRDATA !== 32'h0 || apb_if.PSLVERR !== 1'b0) begin errors++;
      $display("FAIL reset_bus got prdata %h pslverr %b exp 0 0", apb_if.PRDATA, apb_if.PSLVERR); end
    @(negedge clk); rst = 1'b0;
    apb_read(ra(0, 8), d, e);
    checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL reset_result got %h err %b exp 0", d, e); end
    apb_read(ra(1, 12), d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", d); end
    apb_read(ra(0, 4), d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic e; int lat;
    apb_write(ra(0, 4), 32'h0, e);
    apb_write(ra(0, 0), 32'h0305, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_op_err got %b exp 0", e); end
    wait_done(2'b01, lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency got %0d exp 5", lat); end
    apb_read(ra(0, 8), d, e);
    checks++; if (d !== 32'd15) begin errors++; $display("FAIL basic_result got %h exp %h", d, 32'd15); end
    apb_read(ra(0, 12), d, e);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL basic_status1 got %h exp 2", d); end
    apb_read(ra(0, 12), d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_status2 got %h exp 0", d); end
    apb_read(ra(0, 0), d, e);
    checks++; if (d !== 32'h0305) begin errors++; $display("FAIL basic_operand got %h exp 0305", d); end
  endtask

  task automatic test_accumulate();
    logic [31:0] d; logic e; int lat;
    apb_write(ra(0, 4), 32'h1, e);
    apb_write(ra(0, 0), 32'hFE07, e);
    apb_read(ra(0, 12), d, e);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL acc_busy_poll1 got %h exp 1", d); end
    apb_read(ra(0, 12), d, e);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL acc_busy_poll2 got %h exp 1", d); end
    wait_done(2'b01, lat);
    checks++; if (lat < 0) begin errors++; $display("FAIL acc_done_timeout got %0d exp >0", lat); end
    apb_read(ra(0, 8), d, e);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL acc_result got %h exp 1", d); end
    apb_read(ra(0, 12), d, e);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL acc_status got %h exp 2", d); end
    apb_write(ra(0, 4), 32'h3, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL acc_clr_err got %b exp 0", e); end
    apb_read(ra(0, 8), d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL acc_clr_result got %h exp 0", d); end
    apb_read(ra(0, 4), d, e);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL acc_ctrl_read got %h exp 1", d); end
  endtask

  task automatic test_busy_reject();
    logic [31:0] d; logic e; int lat;
    apb_write(ra(1, 0), 32'h0203, e);
    apb_write(ra(0, 0), 32'h0404, e);
    apb_write(ra(1, 0), 32'h0707, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL busy_op_err got %b exp 1", e); end
    wait_done(2'b11, lat);
    checks++; if (lat < 0) begin errors++; $display("FAIL busy_done_timeout got %0d exp >0", lat); end
    apb_read(ra(1, 8), d, e);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL busy_ch1_result got %h exp 6", d); end
    apb_read(ra(1, 0), d, e);
    checks++; if (d !== 32'h0203) begin errors++; $display("FAIL busy_ch1_operand got %h exp 0203", d); end
    apb_read(ra(0, 8), d, e);
    checks++; if (d !== 32'h10) begin errors++; $display("FAIL busy_ch0_result got %h exp 10", d); end
    apb_read(ra(0, 12), d, e);
    apb_read(ra(1, 12), d, e);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL busy_ch1_status got %h exp 2", d); end
    // CLR while busy is rejected; accumulate continues from 16
    apb_write(ra(0, 0), 32'h0101, e);
    apb_write(ra(0, 4), 32'h3, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL busy_clr_err got %b exp 1", e); end
    wait_done(2'b01, lat);
    apb_read(ra(0, 8), d, e);
    checks++; if (d !== 32'h11) begin errors++; $display("FAIL busy_clr_result got %h exp 11", d); end
    apb_read(ra(0, 12), d, e);
    // CTRL with CLR=0 while busy is accepted and switches to overwrite
    apb_write(ra(0, 0), 32'h0101, e);
    apb_write(ra(0, 4), 32'h0, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL busy_ctrl_err got %b exp 0", e); end
    wait_done(2'b01, lat);
    apb_read(ra(0, 8), d, e);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL busy_ovw_result got %h exp 1", d); end
    apb_read(ra(0, 12), d, e);
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic e; int lat;
    apb_write(ra(0, 4), 32'h7, e);
    apb_read(ra(0, 4), d, e);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL ovf_ctrl got %h exp 5", d); end
    apb_write(ra(0, 0), 32'h8080, e);
    wait_done(2'b01, lat);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ovf_irq1 got %b exp 1", irq); end
    apb_read(ra(0, 8), d, e);
    checks++; if (d !== 32'h4000) begin errors++; $display("FAIL ovf_result1 got %h exp 4000", d); end
    apb_read(ra(0, 12), d, e);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL ovf_status1 got %h exp 2", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_clear got %b exp 0", irq); end
    apb_write(ra(0, 0), 32'h8080, e);
    wait_done(2'b01, lat);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ovf_irq2 got %b exp 1", irq); end
    apb_read(ra(0, 8), d, e);
    checks++; if (d !== 32'hFFFF8000) begin errors++; $display("FAIL ovf_result2 got %h exp FFFF8000", d); end
    apb_read(ra(0, 12), d, e);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL ovf_status2 got %h exp 6", d); end
    apb_read(ra(0, 12), d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ovf_status3 got %h exp 0", d); end
  endtask

  task automatic test_decode_errors();
    logic [31:0] d; logic e;
    apb_read(BASE + 32'h20, d, e);
    checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL dec_range got %h err %b exp 0 1", d, e); end
    apb_write(ra(0, 8), 32'h1234, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL dec_wr_result got %b exp 1", e); end
    apb_read(ra(0, 8), d, e);
    checks++; if (d !== 32'hFFFF8000) begin errors++; $display("FAIL dec_result_kept got %h exp FFFF8000", d); end
    apb_read(BASE + 32'h02, d, e);
    checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL dec_misalign got %h err %b exp 0 1", d, e); end
    apb_write(ra(1, 12), 32'h7, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL dec_wr_status got %b exp 1", e); end
    apb_write(BASE - 32'h10, 32'h0101, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL dec_below_base got %b exp 1", e); end
    apb_write(BASE + 32'h22, 32'h0101, e);
    repeat (8) @(posedge clk);
    #1;
    checks++; if (mac_done !== 2'b00) begin errors++; $display("FAIL dec_no_start got %b exp 00", mac_done); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] d; logic e; int late;
    apb_write(ra(1, 0), 32'h0505, e);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (mac_done !== 2'b00) begin errors++; $display("FAIL rst_mac_done got %b exp 00", mac_done); end
    apb_read(ra(1, 12), d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status got %h exp 0", d); end
    apb_read(ra(1, 8), d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_result_ch1 got %h exp 0", d); end
    apb_read(ra(0, 8), d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_result_ch0 got %h exp 0", d); end
    late = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (mac_done !== 2'b00 || irq !== 1'b0) late++;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL rst_late_done got %0d exp 0", late); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    apb_if.PADDR = '0; apb_if.PWDATA = '0; apb_if.PWRITE = 1'b0;
    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0;
    test_reset();
    test_basic();
    test_accumulate();
    test_busy_reject();
    test_overflow();
    test_decode_errors();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_mac_array.md
Name: apb_mac_array

Overview:
- Parametrised APB3 slave with NUM_CH independent signed multiply-accumulate channels.
- Each channel has its own sequential radix-4 Booth multiplier, accumulator, control and status registers, and done interrupt.
- Sits on the peripheral APB bus at SLAVE_BASE.
- Adds accumulate/overwrite mode, accumulator clear, overflow detection, busy protection and an interrupt.

Parameters:
- OPERAND_WIDTH, 8, signed operand width W; even, 4..16.
- NUM_CH, 2, number of MAC channels, 1..16.
- ACC_WIDTH, 2*OPERAND_WIDTH+8, accumulator width; 2W..32.
- SLAVE_BASE, 32'h0000_0000, APB base address.

Ports:
- PCLK  in  1  system-peripheral clock.
- PRESET  in  1  synchronous reset, active-high.
- PADDR  in  32  APB address.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  ready; tied 1, zero wait states.
- PSLVERR  out  1  error, valid in access phase.
- MAC_DONE  out  NUM_CH  per-channel DONE status bit.
- IRQ  out  1  OR over channels of (DONE & IRQ_EN).

Behaviour:
- Reset:
  - PRESET is synchronous and active-high.
  - On reset: all accumulators, CTRL, STATUS and multiplier state go to 0; PRDATA=0; PSLVERR=0; MAC_DONE=0; IRQ=0.
  - Reset mid-operation aborts the multiply with no accumulator update.
- Decode:
  - off = PADDR - SLAVE_BASE; ch = off[7:4]; reg = off[3:2].
  - The address is valid iff off < NUM_CH*16 and off[1:0]==0.
  - An invalid access gives PSLVERR=1 and PRDATA=0, with no state change.
- Transfer timing:
  - A transfer completes in the cycle PSEL & PENABLE.
  - PRDATA and PSLVERR are combinational in that cycle and 0 otherwise.
- Registers per channel:
  - 0x0 OPERAND (W): a=PWDATA[2W-1:W], b=PWDATA[W-1:0], both signed; upper bits ignored. A write starts a multiply. Reads return the last written operands.
  - 0x4 CTRL (R/W): bit0 ACC_EN (1 = acc += a*b, 0 = acc = a*b); bit1 CLR (write-1 self-clearing, acc<=0, reads 0); bit2 IRQ_EN.
  - 0x8 RESULT (RO): acc sign-extended to 32 bits. A write gives PSLVERR.
  - 0xC STATUS: bit0 BUSY (RO); bit1 DONE (sticky, cleared by reading STATUS); bit2 OVF (sticky, cleared by reading STATUS). A write gives PSLVERR.
- Busy rule:
  - A write to OPERAND, or a CTRL write with CLR=1, while BUSY=1 gives PSLVERR=1 and is ignored entirely.
  - A CTRL write with CLR=0 while busy is accepted; the new ACC_EN applies at the update.
- Channel FSM: IDLE -> MUL -> ACC -> IDLE.
  - The OPERAND write is accepted at edge E0. BUSY=1 from E0 onward, and the Booth unit starts.
  - MUL lasts W/2 cycles.
  - The accumulator updates, DONE sets and BUSY clears at edge E0+W/2+1 (W=8: edge E0+5).
  - Back-to-back operations are accepted the cycle BUSY reads 0.
- Arithmetic:
  - Product is 2W signed, sign-extended to ACC_WIDTH.
  - The sum wraps modulo 2^ACC_WIDTH.
  - OVF sets when the operands have equal signs and the result sign differs.
  - The overwrite mode never sets OVF.
  - Booth handles a=b=-2^(W-1) exactly.
- Simultaneous events:
  - DONE or OVF set and a STATUS read in the same cycle: the read returns the old value and the set wins (bit ends 1).
  - Channels operate fully concurrently; only one APB access occurs per cycle.
- MAC_DONE[i] equals DONE of channel i.

Decomposition:
- Package apb_mac_pkg:
  - register offsets (OFF_OPERAND, OFF_CTRL, OFF_RESULT, OFF_STATUS);
  - CTRL and STATUS bit indices;
  - channel FSM state enum (IDLE, MUL, ACC).
- Sub-module booth_r4_seq (parameter W):
  - ports: PCLK, PRESET, start, a, b, product[2W-1:0], done;
  - one-cycle done pulse W/2 cycles after start.
- The top instantiates NUM_CH channels via generate.

Test Plan:
- W=8: write OPERAND ch0 = 0x0305, CTRL=0. STATUS polled -> BUSY for 5 cycles, then RESULT=15, DONE=1. A second STATUS read -> DONE=0.
- CTRL ch0 = 1, then write 0xFE07 (-2*7) -> RESULT=1 (15-14). Then write CTRL = 0x3 (CLR=1, ACC_EN kept 1) -> RESULT=0.
- Write OPERAND ch1 while ch1 BUSY -> PSLVERR=1, and the result reflects the first operands only. A concurrent ch0 operation completes unaffected.
- ACC_WIDTH=16, ACC_EN=1: two writes of 0x8080 (-128*-128=16384 each) -> RESULT=0xFFFF8000, OVF=1, IRQ=1 when IRQ_EN=1.
- NUM_CH=2: read at off 0x20, write to RESULT, read at off 0x02 -> each PSLVERR=1 with PRDATA=0, and no register changes.
- PRESET asserted 2 cycles after an OPERAND write -> BUSY=0, RESULT=0, MAC_DONE=0, and no late DONE after reset release.
